// File: rtl/cpu_jtag_dbg_pkg.sv
// Shared IR encodings, DR lengths and FSM states for the CPU JTAG debug host.
// Pure declarations: no latency and no backpressure.
package cpu_jtag_dbg_pkg;

  localparam int DW = 38;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  localparam logic [5:0] LEN_OCIMEM    = 6'd36;
  localparam logic [5:0] LEN_TRACEMEM  = 6'd38;
  localparam logic [5:0] LEN_BREAK     = 6'd38;
  localparam logic [5:0] LEN_TRACECTRL = 6'd16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IR_UPD,
    ST_IR_WAIT,
    ST_CAPTURE,
    ST_SHIFT,
    ST_UPD,
    ST_UPD_WAIT,
    ST_RSP
  } state_t;

  function automatic logic [5:0] dr_len(input logic [1:0] ir);
    logic [5:0] len;
    case (ir)
      IR_OCIMEM:   len = LEN_OCIMEM;
      IR_TRACEMEM: len = LEN_TRACEMEM;
      IR_BREAK:    len = LEN_BREAK;
      default:     len = LEN_TRACECTRL;
    endcase
    return len;
  endfunction

  function automatic logic [DW-1:0] dr_mask(input logic [5:0] len);
    return {DW{1'b1}} >> (6'(DW) - len);
  endfunction

endpackage

// File: rtl/cpu_jtag_debug_host_if.sv
// Command/response handshake plus the TAP-side signals toward the debug module.
// slave = the host block, master = the command issuer / debug-module side.
interface cpu_jtag_debug_host_if;
  import cpu_jtag_dbg_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_ir;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;
  logic [1:0]    ir_out;
  logic          tdo;
  logic [1:0]    ir_in;
  logic          usr1;
  logic          ena;
  logic          shift;
  logic          tdi;
  logic          jtag_state_sdr;
  logic          jtag_state_udr;
  logic          rti;

  modport slave (
    input  cmd_valid, cmd_ir, cmd_wdata, ir_out, tdo,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
           ir_in, usr1, ena, shift, tdi, jtag_state_sdr, jtag_state_udr, rti
  );

  modport master (
    output cmd_valid, cmd_ir, cmd_wdata, ir_out, tdo,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
           ir_in, usr1, ena, shift, tdi, jtag_state_sdr, jtag_state_udr, rti
  );

endinterface

// File: rtl/cpu_jtag_dbg_shifter.sv
// DR shift register: parallel load of write data, LSB-first tdi out, tdo captured at bit len-1.
// One bit per cycle while i_shift_en; no backpressure.
module cpu_jtag_dbg_shifter
  import cpu_jtag_dbg_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_load_dat,
  input  logic [5:0]    i_len,
  input  logic          i_shift_en,
  input  logic          i_tdo,
  output logic          o_tdi,
  output logic          o_last,
  output logic [DW-1:0] o_sr
);

  logic [DW-1:0] r_sr;
  logic [5:0]    r_len;
  logic [5:0]    r_cnt;
  logic [DW-1:0] w_ins;

  // Captured bit enters at the top of the active window so the result ends right-aligned.
  assign w_ins = {{(DW-1){1'b0}}, i_tdo} << (r_len - 6'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr  <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_load_dat & dr_mask(i_len);
      r_len <= i_len;
      r_cnt <= '0;
    end else if (i_shift_en) begin
      r_sr  <= (r_sr >> 1) | w_ins;
      r_cnt <= r_cnt + 6'd1;
    end
  end

  assign o_tdi  = r_sr[0];
  assign o_last = (r_cnt == (r_len - 6'd1));
  assign o_sr   = r_sr;

endmodule

// File: rtl/cpu_jtag_debug_host.sv
// Virtual-JTAG initiator: IR update, DR capture/shift/update, then a one-cycle response pulse.
// Latency N+UPD_WAIT+3 (plus 1+IR_WAIT with IR phase); cmd_ready low while busy, no queueing.
module cpu_jtag_debug_host
  import cpu_jtag_dbg_pkg::*;
#(
  parameter int IR_WAIT      = 2,
  parameter int UPD_WAIT     = 4,
  parameter bit SKIP_SAME_IR = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cpu_jtag_debug_host_if.slave  bus
);

  state_t        r_state, w_next;
  logic [3:0]    r_wait;
  logic          r_cmd_ready, r_rti, r_rsp_valid;
  logic          r_usr1, r_ena, r_shift, r_sdr, r_udr;
  logic [1:0]    r_ir_in, r_last_ir, r_status;
  logic          r_last_vld;
  logic [DW-1:0] r_rdata;
  logic          w_accept, w_skip, w_load, w_shift_en, w_last, w_tdi;
  logic [DW-1:0] w_sr;

  assign w_accept = bus.cmd_valid && r_cmd_ready;
  assign w_skip   = SKIP_SAME_IR && r_last_vld && (bus.cmd_ir == r_last_ir);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_shift_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
          w_next = w_skip ? ST_CAPTURE : ST_IR_UPD;
        end
      end
      ST_IR_UPD:   w_next = ST_IR_WAIT;
      ST_IR_WAIT:  if (r_wait == 4'(IR_WAIT - 1)) w_next = ST_CAPTURE;
      ST_CAPTURE:  w_next = ST_SHIFT;
      ST_SHIFT: begin
        w_shift_en = 1'b1;
        if (w_last) w_next = ST_UPD;
      end
      ST_UPD:      w_next = ST_UPD_WAIT;
      ST_UPD_WAIT: if (r_wait == 4'(UPD_WAIT - 1)) w_next = ST_RSP;
      ST_RSP:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // TAP outputs are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait      <= '0;
      r_cmd_ready <= 1'b1;
      r_rti       <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_usr1      <= 1'b0;
      r_ena       <= 1'b0;
      r_shift     <= 1'b0;
      r_sdr       <= 1'b0;
      r_udr       <= 1'b0;
      r_ir_in     <= '0;
      r_last_ir   <= '0;
      r_last_vld  <= 1'b0;
      r_status    <= '0;
      r_rdata     <= '0;
    end else begin
      r_wait      <= (w_next != r_state) ? 4'd0 : r_wait + 4'd1;
      r_cmd_ready <= (w_next == ST_IDLE);
      r_rti       <= (w_next == ST_IDLE);
      r_rsp_valid <= (w_next == ST_RSP);
      r_usr1      <= (w_next == ST_IR_UPD);
      r_ena       <= (w_next inside {ST_IR_UPD, ST_CAPTURE, ST_SHIFT, ST_UPD});
      r_shift     <= (w_next == ST_SHIFT);
      r_sdr       <= (w_next == ST_SHIFT);
      r_udr       <= (w_next == ST_IR_UPD) || (w_next == ST_UPD);
      if (r_state == ST_IDLE && w_next == ST_IR_UPD) r_ir_in <= bus.cmd_ir;
      if (r_state == ST_IR_UPD) begin
        r_last_ir  <= r_ir_in;
        r_last_vld <= 1'b1;
      end
      if (r_state == ST_IR_WAIT && w_next == ST_CAPTURE) r_status <= bus.ir_out;
      if (w_next == ST_RSP) r_rdata <= w_sr;
    end
  end

  cpu_jtag_dbg_shifter u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_dat (bus.cmd_wdata),
    .i_len      (dr_len(bus.cmd_ir)),
    .i_shift_en (w_shift_en),
    .i_tdo      (bus.tdo),
    .o_tdi      (w_tdi),
    .o_last     (w_last),
    .o_sr       (w_sr)
  );

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.rti            = r_rti;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rdata;
  assign bus.rsp_status     = r_status;
  assign bus.ir_in          = r_ir_in;
  assign bus.usr1           = r_usr1;
  assign bus.ena            = r_ena;
  assign bus.shift          = r_shift;
  assign bus.tdi            = w_tdi;
  assign bus.jtag_state_sdr = r_sdr;
  assign bus.jtag_state_udr = r_udr;

endmodule

// File: tb/tb_cpu_jtag_debug_host.sv
// Bench for cpu_jtag_debug_host: a behavioural debug-module slave plus a scoreboard of expected responses.
module tb_cpu_jtag_debug_host;
  import cpu_jtag_dbg_pkg::*;

  localparam int IRW = 2;
  localparam int UPW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cpu_jtag_debug_host_if ifc ();

  cpu_jtag_debug_host #(.IR_WAIT(IRW), .UPD_WAIT(UPW), .SKIP_SAME_IR(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  int nt = 0;
  int nf = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nt++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int dr_bits(input logic [1:0] ir);
    case (ir)
      2'b00:   return 36;
      2'b01:   return 38;
      2'b10:   return 38;
      default: return 16;
    endcase
  endfunction

  function automatic logic [37:0] low_bits(input logic [37:0] v, input int n);
    logic [37:0] m;
    m = (n >= 38) ? '1 : ((38'd1 << n) - 38'd1);
    return v & m;
  endfunction

  // Debug-module slave: presents capture bit k on tdo during shift k and collects tdi bit k.
  logic [37:0] s_cap = '0;
  logic [37:0] s_capl = '0;
  logic [37:0] s_tdi = '0;
  logic [37:0] s_jdo = '0;
  logic [1:0]  s_ir = '0;
  int s_bidx = 0;
  int s_nshift = 0;
  int s_nusr1 = 0;

  assign ifc.tdo = (s_bidx < 38) ? s_capl[s_bidx[5:0]] : 1'b0;

  always @(posedge clk) begin
    if (ifc.usr1) s_nusr1 <= s_nusr1 + 1;
    if (ifc.usr1 && ifc.ena && ifc.jtag_state_udr) s_ir <= ifc.ir_in;
    if (ifc.ena && !ifc.usr1 && !ifc.shift && !ifc.jtag_state_udr) begin
      s_capl <= s_cap;
      s_tdi  <= '0;
      s_bidx <= 0;
    end else if (ifc.ena && ifc.shift) begin
      if (s_bidx < 38) s_tdi[s_bidx[5:0]] <= ifc.tdi;
      s_bidx   <= s_bidx + 1;
      s_nshift <= s_nshift + 1;
    end
    if (ifc.ena && ifc.jtag_state_udr && !ifc.usr1) s_jdo <= s_tdi;
  end

  typedef struct {
    logic [37:0] rdata;
    logic [37:0] jdo;
    logic [1:0]  status;
    logic [1:0]  ir;
    int lat, nshift, nusr1, cyc0, shift_base, usr1_base;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always @(negedge clk) begin
    if (reset_n && ifc.rsp_valid) begin
      if (q.size() == 0) begin
        nt++;
        nf++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with rdata %0h, required no response", ifc.rsp_rdata);
      end else begin
        e = q.pop_front();
        chk("rsp_rdata",  64'(ifc.rsp_rdata), 64'(e.rdata));
        chk("rsp_status", 64'(ifc.rsp_status), 64'(e.status));
        chk("latency",    64'(cyc - e.cyc0), 64'(e.lat));
        chk("shift_cycles", 64'(s_nshift - e.shift_base), 64'(e.nshift));
        chk("usr1_pulses",  64'(s_nusr1 - e.usr1_base), 64'(e.nusr1));
        chk("jdo",        64'(s_jdo), 64'(e.jdo));
        chk("ir_sel",     64'(s_ir), 64'(e.ir));
      end
    end
  end

  logic [1:0] m_last_ir = '0;
  bit         m_last_vld = 1'b0;
  logic [1:0] m_status = '0;

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifc.cmd_ready) begin
        ok = 1'b1;
        return;
      end
    end
    nt++;
    nf++;
    $display("FAIL ready_timeout: cmd_ready=%0b after 400 cycles, required 1", ifc.cmd_ready);
  endtask

  task automatic issue(input logic [1:0] ir, input logic [37:0] wd,
                       input logic [37:0] cap, input logic [1:0] irout);
    bit ok;
    bit skip;
    int n;
    exp_t x;
    wait_ready(ok);
    if (!ok) return;
    n = dr_bits(ir);
    skip = m_last_vld && (m_last_ir == ir);
    if (!skip) begin
      m_status   = irout;
      m_last_ir  = ir;
      m_last_vld = 1'b1;
    end
    x.rdata      = low_bits(cap, n);
    x.jdo        = low_bits(wd, n);
    x.status     = m_status;
    x.ir         = ir;
    x.lat        = n + UPW + 3 + (skip ? 0 : 1 + IRW);
    x.nshift     = n;
    x.nusr1      = skip ? 0 : 1;
    x.cyc0       = cyc;
    x.shift_base = s_nshift;
    x.usr1_base  = s_nusr1;
    q.push_back(x);
    s_cap         = cap;
    ifc.ir_out    = irout;
    ifc.cmd_ir    = ir;
    ifc.cmd_wdata = wd;
    ifc.cmd_valid = 1'b1;
    // Keep requesting with junk while busy: none of it may be accepted or alter this command.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ifc.cmd_ir    = 2'($urandom_range(0, 3));
      ifc.cmd_wdata = 38'({$urandom(), $urandom()});
    end
    ifc.cmd_valid = 1'b0;
  endtask

  function automatic logic [37:0] rnd38();
    return 38'({$urandom(), $urandom()});
  endfunction

  logic [37:0] w;
  bit ok_w;

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_ir    = '0;
    ifc.cmd_wdata = '0;
    ifc.ir_out    = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_flags", 64'({ifc.cmd_ready, ifc.rti, ifc.ena, ifc.rsp_valid}), 64'(4'b1100));
    end
    chk("idle_rsp_regs", 64'({ifc.rsp_status, ifc.rsp_rdata}), 64'd0);

    issue(2'b00, 38'h0_2345_6789, {3'b000, 32'hDEADBEEF, 1'b1}, 2'b01);
    issue(2'b00, rnd38(), rnd38(), 2'b10);
    w = rnd38();
    w[15] = 1'b1;
    issue(2'b11, w, rnd38(), 2'($urandom_range(0, 3)));
    issue(2'b01, rnd38(), 38'h2A_5A5A_5A5A, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 20; i++)
      issue(2'($urandom_range(0, 3)), rnd38(), rnd38(), 2'($urandom_range(0, 3)));

    // Reset in the middle of a shift: outputs must drop to reset values without a clock edge.
    issue(2'b10, rnd38(), rnd38(), 2'b11);
    ok_w = 1'b0;
    for (int i = 0; i < 200 && !ok_w; i++) begin
      if (ifc.shift && s_bidx == 10) ok_w = 1'b1;
      else @(negedge clk);
    end
    if (!ok_w) begin
      nt++;
      nf++;
      $display("FAIL shift_bit10_timeout: shift=%0b bit=%0d, required shift at bit 10", ifc.shift, s_bidx);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_ctl",
        64'({ifc.cmd_ready, ifc.rti, ifc.rsp_valid, ifc.usr1, ifc.ena, ifc.shift, ifc.tdi,
             ifc.jtag_state_sdr, ifc.jtag_state_udr, ifc.ir_in, ifc.rsp_status}),
        64'(13'b11_0000_0000_000));
    chk("async_reset_rdata", 64'(ifc.rsp_rdata), 64'd0);
    q.delete();
    m_last_vld = 1'b0;
    m_status   = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    issue(2'b10, rnd38(), rnd38(), 2'b01);
    issue(2'($urandom_range(0, 3)), rnd38(), rnd38(), 2'($urandom_range(0, 3)));

    wait_ready(ok_w);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("pending_rsp", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
